// File: rtl/xt_hb_system_timer_pkg.sv
// XT_BUS shared types plus SYSTEM_TIMER register map.
//   hb_slave_t : shared request from the HB domain decoder (raddr, waddr, wdata)
//   sel_t      : per-slave read/write strobes
//   MTIME_LO..MTIMECMP_HI : word offsets relative to the timer base word
package xt_hb_system_timer_pkg;

    localparam int unsigned HB_AW  = 32;
    localparam int unsigned HB_DW  = 32;
    localparam int unsigned WIDX_W = 6;

    typedef struct packed {
        logic [HB_AW-1:0] raddr;
        logic [HB_AW-1:0] waddr;
        logic [HB_DW-1:0] wdata;
    } hb_slave_t;

    typedef struct packed {
        logic ren;
        logic wen;
    } sel_t;

    localparam int unsigned MTIME_LO    = 0;
    localparam int unsigned MTIME_HI    = 1;
    localparam int unsigned MTIMECMP_LO = 2;
    localparam int unsigned MTIMECMP_HI = 3;

    typedef enum logic [2:0] {
        REG_MTIME_LO    = 3'(MTIME_LO),
        REG_MTIME_HI    = 3'(MTIME_HI),
        REG_MTIMECMP_LO = 3'(MTIMECMP_LO),
        REG_MTIMECMP_HI = 3'(MTIMECMP_HI),
        REG_NONE        = 3'd4
    } reg_sel_e;

    // Map an absolute word index onto a timer register; anything outside base..base+3 is REG_NONE.
    function automatic reg_sel_e decode_word(input logic [WIDX_W-1:0] widx,
                                             input int unsigned        base);
        int unsigned idx;
        idx = 32'(widx);
        if (idx < base || (idx - base) > 32'd3) begin
            return REG_NONE;
        end
        return reg_sel_e'(3'(idx - base));
    endfunction

endpackage

// File: rtl/xt_tick_gen.sv
// Prescaler: asserts tick once every PRESCALE clocks (every clock when PRESCALE=1).
//   hb_clk : clock
//   hb_rst : synchronous active-high reset, counter returns to 0
//   tick   : high in the cycle where the counter sits at PRESCALE-1
module xt_tick_gen #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic hb_clk,
    input  logic hb_rst,
    output logic tick
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] pcnt;

    assign tick = (pcnt == CW'(PRESCALE - 1));

    // Counter 0..PRESCALE-1, wrapping on tick.
    always_ff @(posedge hb_clk) begin
        if (hb_rst) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + CW'(1);
        end
    end

endmodule

// File: rtl/xt_hb_system_timer.sv
// SYSTEM_TIMER slave on XT_HB: 64-bit mtime / mtimecmp with a level timer interrupt.
//   hb_clk    : bus clock
//   hb_rst    : synchronous active-high reset
//   xt_hb     : shared request (word index = addr[7:2])
//   hb_sel    : ren/wen strobes for this slave
//   hb_rdata  : registered read data, held until the next ren
//   timer_irq : registered level interrupt, mtime >= mtimecmp
module xt_hb_system_timer
    import xt_hb_system_timer_pkg::*;
#(
    parameter int unsigned PRESCALE        = 1,
    parameter int unsigned MTIME_BASE_WORD = 5
) (
    input  logic        hb_clk,
    input  logic        hb_rst,
    input  hb_slave_t   xt_hb,
    input  sel_t        hb_sel,
    output logic [31:0] hb_rdata,
    output logic        timer_irq
);

    logic        tick;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [31:0] hi_snap;
    reg_sel_e    rsel;
    reg_sel_e    wsel;
    logic [31:0] lo_inc;
    logic        wr_lo;
    logic        wr_hi;
    logic        unused_addr_bits;

    xt_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .hb_clk (hb_clk),
        .hb_rst (hb_rst),
        .tick   (tick)
    );

    assign rsel   = decode_word(xt_hb.raddr[7:2], MTIME_BASE_WORD);
    assign wsel   = decode_word(xt_hb.waddr[7:2], MTIME_BASE_WORD);
    assign wr_lo  = hb_sel.wen && (wsel == REG_MTIME_LO);
    assign wr_hi  = hb_sel.wen && (wsel == REG_MTIME_HI);
    // Low-word increment used when the high word is overwritten; its carry is dropped.
    assign lo_inc = mtime[31:0] + 32'(tick);

    assign unused_addr_bits = ^{xt_hb.raddr[31:8], xt_hb.raddr[1:0],
                                xt_hb.waddr[31:8], xt_hb.waddr[1:0]};

    // mtime: a write to either half takes priority over the carry chain.
    always_ff @(posedge hb_clk) begin
        if (hb_rst) begin
            mtime <= '0;
        end else if (wr_lo) begin
            mtime[31:0] <= xt_hb.wdata;
        end else if (wr_hi) begin
            mtime[63:32] <= xt_hb.wdata;
            mtime[31:0]  <= lo_inc;
        end else if (tick) begin
            mtime <= mtime + 64'(1);
        end
    end

    // mtimecmp halves.
    always_ff @(posedge hb_clk) begin
        if (hb_rst) begin
            mtimecmp <= '1;
        end else if (hb_sel.wen) begin
            if (wsel == REG_MTIMECMP_LO) begin
                mtimecmp[31:0] <= xt_hb.wdata;
            end
            if (wsel == REG_MTIMECMP_HI) begin
                mtimecmp[63:32] <= xt_hb.wdata;
            end
        end
    end

    // Read path samples pre-write values; a lo read also snapshots the hi word.
    always_ff @(posedge hb_clk) begin
        if (hb_rst) begin
            hb_rdata <= '0;
            hi_snap  <= '0;
        end else if (hb_sel.ren) begin
            unique case (rsel)
                REG_MTIME_LO: begin
                    hb_rdata <= mtime[31:0];
                    hi_snap  <= mtime[63:32];
                end
                REG_MTIME_HI:    hb_rdata <= hi_snap;
                REG_MTIMECMP_LO: hb_rdata <= mtimecmp[31:0];
                REG_MTIMECMP_HI: hb_rdata <= mtimecmp[63:32];
                default:         hb_rdata <= '0;
            endcase
        end
    end

    // Level interrupt from the current register values.
    always_ff @(posedge hb_clk) begin
        if (hb_rst) begin
            timer_irq <= 1'b0;
        end else begin
            timer_irq <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: tb/tb_xt_hb_system_timer.sv
// Self-checking bench: two timers (PRESCALE=1 and 4) share one bus stimulus and are
// compared every cycle against a behavioural model, plus directed constant checks.
module tb_xt_hb_system_timer;
    import xt_hb_system_timer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    hb_slave_t   bus;
    sel_t        sel;
    logic [31:0] rdata0, rdata1;
    logic        irq0, irq1;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state, index 0 -> PRESCALE 1, index 1 -> PRESCALE 4.
    logic [63:0] m_mt   [2];
    logic [63:0] m_cmp  [2];
    logic [31:0] m_snap [2];
    logic [31:0] m_rd   [2];
    logic        m_irq  [2];
    longint unsigned m_cyc [2];

    always #5 clk = ~clk;

    xt_hb_system_timer #(.PRESCALE(1), .MTIME_BASE_WORD(5)) dut0 (
        .hb_clk(clk), .hb_rst(rst), .xt_hb(bus), .hb_sel(sel),
        .hb_rdata(rdata0), .timer_irq(irq0)
    );

    xt_hb_system_timer #(.PRESCALE(4), .MTIME_BASE_WORD(5)) dut1 (
        .hb_clk(clk), .hb_rst(rst), .xt_hb(bus), .hb_sel(sel),
        .hb_rdata(rdata1), .timer_irq(irq1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned ps(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    // One clock edge of the reference model, using the inputs present before the edge.
    task automatic model_edge(input int k);
        logic        tk;
        logic [63:0] mt;
        logic [63:0] ct;
        int          ro;
        int          wo;
        if (rst) begin
            m_mt[k]   = 64'd0;
            m_cmp[k]  = '1;
            m_snap[k] = 32'd0;
            m_rd[k]   = 32'd0;
            m_irq[k]  = 1'b0;
            m_cyc[k]  = 0;
        end else begin
            tk = ((m_cyc[k] % ps(k)) == ps(k) - 1);
            m_cyc[k]++;
            mt = m_mt[k];
            ct = m_cmp[k];
            m_irq[k] = (mt >= ct);
            ro = int'(bus.raddr[7:2]) - 5;
            wo = int'(bus.waddr[7:2]) - 5;
            if (sel.ren) begin
                case (ro)
                    0: begin m_rd[k] = mt[31:0]; m_snap[k] = mt[63:32]; end
                    1: m_rd[k] = m_snap[k];
                    2: m_rd[k] = ct[31:0];
                    3: m_rd[k] = ct[63:32];
                    default: m_rd[k] = 32'd0;
                endcase
            end
            if (sel.wen && wo == 0)      m_mt[k] = {mt[63:32], bus.wdata};
            else if (sel.wen && wo == 1) m_mt[k] = {bus.wdata, mt[31:0] + 32'(tk)};
            else                         m_mt[k] = mt + 64'(tk);
            if (sel.wen && wo == 2) m_cmp[k][31:0]  = bus.wdata;
            if (sel.wen && wo == 3) m_cmp[k][63:32] = bus.wdata;
        end
    endtask

    task automatic cyc(input logic r, input logic ren, input logic [5:0] rw,
                       input logic wen, input logic [5:0] ww, input logic [31:0] wd);
        rst       = r;
        sel.ren   = ren;
        sel.wen   = wen;
        bus.raddr = {24'h0, rw, 2'(r ? 2'b01 : 2'b00)};
        bus.waddr = {24'h0, ww, 2'b00};
        bus.wdata = wd;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        chk("rdata_p1", 64'(rdata0), 64'(m_rd[0]));
        chk("irq_p1",   64'(irq0),   64'(m_irq[0]));
        chk("rdata_p4", 64'(rdata1), 64'(m_rd[1]));
        chk("irq_p4",   64'(irq1),   64'(m_irq[1]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0);
    endtask

    task automatic rd(input logic [5:0] w);
        cyc(1'b0, 1'b1, w, 1'b0, 6'd0, 32'd0);
    endtask

    task automatic wr(input logic [5:0] w, input logic [31:0] d);
        cyc(1'b0, 1'b0, 6'd0, 1'b1, w, d);
    endtask

    initial begin
        rst = 1'b1;
        sel = '0;
        bus = '0;

        // Reset, free run, coherent read.
        cyc(1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0);
        idle(10);
        rd(6'd5);
        chk("t1_lo_p1", 64'(rdata0), 64'd10);
        chk("t1_lo_p4", 64'(rdata1), 64'd2);
        rd(6'd6);
        chk("t1_hi_p1", 64'(rdata0), 64'd0);
        chk("t1_irq_p1", 64'(irq0), 64'd0);

        cyc(1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0);
        idle(16);
        rd(6'd5);
        chk("t1b_lo_p1", 64'(rdata0), 64'd16);
        chk("t1b_lo_p4", 64'(rdata1), 64'd4);

        // Carry from lo into hi and snapshot coherence.
        wr(6'd6, 32'd0);
        wr(6'd5, 32'hFFFF_FFFE);
        idle(3);
        rd(6'd5);
        chk("t2_lo_p1", 64'(rdata0), 64'd1);
        rd(6'd6);
        chk("t2_snap_p1", 64'(rdata0), 64'd1);

        // Compare match timing and clearing.
        wr(6'd6, 32'd0);
        wr(6'd5, 32'h10);
        wr(6'd8, 32'd0);
        wr(6'd7, 32'h20);
        idle(13);
        chk("t3_irq_pre", 64'(irq0), 64'd0);
        idle(1);
        chk("t3_irq_at", 64'(irq0), 64'd0);
        idle(1);
        chk("t3_irq_rise", 64'(irq0), 64'd1);
        wr(6'd7, 32'h100);
        chk("t3_irq_hold", 64'(irq0), 64'd1);
        idle(1);
        chk("t3_irq_drop", 64'(irq0), 64'd0);

        // Write to mtime_lo on a tick cycle suppresses the increment.
        for (int i = 0; i < 4 && (m_cyc[1] % 4) != 3; i++) idle(1);
        wr(6'd5, 32'h50);
        rd(6'd5);
        chk("t4_lo_p1", 64'(rdata0), 64'h50);
        chk("t4_lo_p4", 64'(rdata1), 64'h50);

        // Snapshot holds across a live hi write.
        rd(6'd5);
        wr(6'd6, 32'hAB);
        rd(6'd6);
        chk("t5_old_p1", 64'(rdata0), 64'd0);
        chk("t5_old_p4", 64'(rdata1), 64'd0);
        rd(6'd5);
        rd(6'd6);
        chk("t5_new_p1", 64'(rdata0), 64'hAB);
        chk("t5_new_p4", 64'(rdata1), 64'hAB);

        // Same-word read and write returns the pre-write value.
        cyc(1'b0, 1'b1, 6'd7, 1'b1, 6'd7, 32'h1234);
        chk("rw_pre_p1", 64'(rdata0), 64'h100);
        rd(6'd7);
        chk("rw_post_p1", 64'(rdata0), 64'h1234);

        // Reset during a pending read.
        wr(6'd8, 32'd0);
        wr(6'd7, 32'd0);
        idle(1);
        chk("t6_irq_set", 64'(irq0), 64'd1);
        rd(6'd5);
        cyc(1'b1, 1'b1, 6'd7, 1'b1, 6'd5, 32'hDEAD_BEEF);
        chk("t6_rdata_p1", 64'(rdata0), 64'd0);
        chk("t6_irq_p1",   64'(irq0),   64'd0);
        chk("t6_irq_p4",   64'(irq1),   64'd0);
        rd(6'd7);
        chk("t6_cmplo", 64'(rdata0), 64'hFFFF_FFFF);
        rd(6'd8);
        chk("t6_cmphi", 64'(rdata0), 64'hFFFF_FFFF);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] d;
            case ($urandom % 4)
                0:       d = 32'hFFFF_FFFF - ($urandom % 4);
                1:       d = $urandom % 8;
                default: d = $urandom;
            endcase
            cyc(1'(($urandom % 300) == 0), 1'($urandom % 2), 6'(3 + $urandom % 7),
                1'(($urandom % 3) == 0), 6'(3 + $urandom % 7), d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
